// File: rtl/res_station_bank.sv
// Multi-entry Tomasulo reservation station: issue, CDB snoop, fixed-priority FU dispatch.
// Optional macro RS_CDB_BYPASS_EN: capture a same-cycle CDB broadcast at issue time.
module res_station_bank #(
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 3,
    parameter int OP_W      = 3,
    parameter int N_ENTRIES = 2,
    parameter int BASE_TAG  = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Issue_valid,
    output logic                 Issue_ready,
    output logic [TAG_W-1:0]     Issue_tag,
    input  logic [OP_W-1:0]      Issue_op,
    input  logic [DATA_W-1:0]    Issue_Vj,
    input  logic [DATA_W-1:0]    Issue_Vk,
    input  logic [TAG_W-1:0]     Issue_Qj,
    input  logic [TAG_W-1:0]     Issue_Qk,
    input  logic                 Cdb_valid,
    input  logic [TAG_W-1:0]     Cdb_tag,
    input  logic [DATA_W-1:0]    Cdb_data,
    output logic                 Fu_valid,
    input  logic                 Fu_ready,
    output logic [OP_W-1:0]      Fu_op,
    output logic [DATA_W-1:0]    Fu_A,
    output logic [DATA_W-1:0]    Fu_B,
    output logic [TAG_W-1:0]     Fu_tag,
    output logic [N_ENTRIES-1:0] Busy
);

    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    typedef enum logic [1:0] {
        ST_FREE,
        ST_WAIT,
        ST_READY,
        ST_EXEC
    } state_t;

    state_t            state [N_ENTRIES];
    logic [OP_W-1:0]   op_q  [N_ENTRIES];
    logic [DATA_W-1:0] vj_q  [N_ENTRIES];
    logic [DATA_W-1:0] vk_q  [N_ENTRIES];
    logic [TAG_W-1:0]  qj_q  [N_ENTRIES];
    logic [TAG_W-1:0]  qk_q  [N_ENTRIES];

    logic              issue_any;
    logic [IDX_W-1:0]  issue_idx;
    logic              issue_fire;
    logic              fu_any;
    logic [IDX_W-1:0]  fu_idx;
    logic              fu_fire;
    logic [DATA_W-1:0] iss_vj;
    logic [DATA_W-1:0] iss_vk;
    logic [TAG_W-1:0]  iss_qj;
    logic [TAG_W-1:0]  iss_qk;

    // Tag 0 means "value present", so a zero tag on either side never matches.
    function automatic logic cdb_hit(input logic vld, input logic [TAG_W-1:0] ctag,
                                     input logic [TAG_W-1:0] q);
        return vld && (ctag != '0) && (ctag == q);
    endfunction

    function automatic logic [TAG_W-1:0] entry_tag(input int idx);
        return TAG_W'(BASE_TAG + idx);
    endfunction

    always_comb begin
        issue_any = 1'b0;
        issue_idx = '0;
        fu_any    = 1'b0;
        fu_idx    = '0;
        // Scan downward so the lowest matching index wins.
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (state[i] == ST_FREE) begin
                issue_any = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (state[i] == ST_READY) begin
                fu_any = 1'b1;
                fu_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            Busy[i] = (state[i] != ST_FREE);
        end
    end

    assign issue_fire  = Issue_valid && issue_any;
    assign fu_fire     = fu_any && Fu_ready;
    assign Issue_ready = issue_any;
    assign Issue_tag   = issue_any ? entry_tag(int'(issue_idx)) : '0;

    assign Fu_valid = fu_any;
    assign Fu_op    = fu_any ? op_q[fu_idx] : '0;
    assign Fu_A     = fu_any ? vj_q[fu_idx] : '0;
    assign Fu_B     = fu_any ? vk_q[fu_idx] : '0;
    assign Fu_tag   = fu_any ? entry_tag(int'(fu_idx)) : '0;

`ifdef RS_CDB_BYPASS_EN
    always_comb begin
        iss_vj = Issue_Vj;
        iss_qj = Issue_Qj;
        iss_vk = Issue_Vk;
        iss_qk = Issue_Qk;
        if (cdb_hit(Cdb_valid, Cdb_tag, Issue_Qj)) begin
            iss_vj = Cdb_data;
            iss_qj = '0;
        end
        if (cdb_hit(Cdb_valid, Cdb_tag, Issue_Qk)) begin
            iss_vk = Cdb_data;
            iss_qk = '0;
        end
    end
`else
    assign iss_vj = Issue_Vj;
    assign iss_vk = Issue_Vk;
    assign iss_qj = Issue_Qj;
    assign iss_qk = Issue_Qk;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                state[i] <= ST_FREE;
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                case (state[i])
                    ST_FREE: begin
                        if (issue_fire && (issue_idx == IDX_W'(i))) begin
                            op_q[i]  <= Issue_op;
                            vj_q[i]  <= iss_vj;
                            vk_q[i]  <= iss_vk;
                            qj_q[i]  <= iss_qj;
                            qk_q[i]  <= iss_qk;
                            state[i] <= ((iss_qj == '0) && (iss_qk == '0)) ? ST_READY : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (cdb_hit(Cdb_valid, Cdb_tag, qj_q[i])) begin
                            vj_q[i] <= Cdb_data;
                            qj_q[i] <= '0;
                        end
                        if (cdb_hit(Cdb_valid, Cdb_tag, qk_q[i])) begin
                            vk_q[i] <= Cdb_data;
                            qk_q[i] <= '0;
                        end
                        if (((qj_q[i] == '0) || cdb_hit(Cdb_valid, Cdb_tag, qj_q[i])) &&
                            ((qk_q[i] == '0) || cdb_hit(Cdb_valid, Cdb_tag, qk_q[i]))) begin
                            state[i] <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (fu_fire && (fu_idx == IDX_W'(i))) begin
                            state[i] <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        // Held until the FU broadcasts this entry's own result.
                        if (cdb_hit(Cdb_valid, Cdb_tag, entry_tag(i))) begin
                            state[i] <= ST_FREE;
                        end
                    end
                    default: state[i] <= ST_FREE;
                endcase
            end
        end
    end

endmodule

// File: doc/res_station_bank.md
# res_station_bank

Parametrised multi-entry reservation station for the Tomasulo datapath. Accepts one instruction per cycle from the issue stage and tags it with its entry's station tag. Captures pending operands by snooping the common data bus (CDB), and dispatches ready entries to one functional unit over a valid/ready handshake. An entry stays reserved until its own result is broadcast on the CDB.

## Interface
Parameters:
- DATA_W, 16, operand/result width
- TAG_W, 3, station tag width; tag 0 means "value present"
- OP_W, 3, opcode width
- N_ENTRIES, 2, number of entries (1..2^TAG_W-1)
- BASE_TAG, 1, tag of entry 0; entry i has tag BASE_TAG+i; must be >=1 and BASE_TAG+N_ENTRIES-1 <= 2^TAG_W-1

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- Issue_valid  in  1  issue stage offers an instruction
- Issue_ready  out  1  at least one entry FREE
- Issue_tag  out  TAG_W  tag the offered instruction will receive (lowest-index FREE entry); 0 when Issue_ready=0
- Issue_op  in  OP_W  opcode
- Issue_Vj, Issue_Vk  in  DATA_W  operand values (meaningful when matching Q is 0)
- Issue_Qj, Issue_Qk  in  TAG_W  producing-station tags, 0 = ready
- Cdb_valid  in  1  result broadcast this cycle
- Cdb_tag  in  TAG_W  producing station of broadcast
- Cdb_data  in  DATA_W  broadcast value
- Fu_valid  out  1  a READY entry is offered to the FU
- Fu_ready  in  1  FU accepts this cycle
- Fu_op  out  OP_W  opcode of offered entry
- Fu_A, Fu_B  out  DATA_W  operands of offered entry
- Fu_tag  out  TAG_W  tag of offered entry (FU returns it on CDB)
- Busy  out  N_ENTRIES  bit i = entry i not FREE

## Operation
- Per-entry state: FREE, WAIT (operand pending), READY, EXEC (sent to FU, awaiting own CDB result).
- Issue fires on Issue_valid && Issue_ready at the edge. Lowest FREE entry loads op, V, and Q. It goes to READY if both captured Q are 0, else WAIT.
- Snoop: in WAIT, Cdb_valid with Cdb_tag == Qj (Qj != 0) loads Vj <= Cdb_data, Qj <= 0. Same for Qk independently. Both may capture in one cycle. WAIT -> READY at the edge where both Q become 0.
- Dispatch: Fu_valid = any READY entry. Fixed priority, lowest index. Fu_* driven combinationally from the selected entry, all zero when Fu_valid=0. Fu_valid && Fu_ready moves the selected entry to EXEC.
- Free: entry in EXEC with Cdb_valid && Cdb_tag == its tag -> FREE. CDB tags matching entries in other states are ignored for freeing.
- Cdb_tag 0 never matches anything.
- Issue_valid while Issue_ready=0: ignored, no state change.

## Timing
- Reset (any time, including mid-operation): all entries FREE, V/Q/op cleared. Busy=0, Fu_valid=0, Fu_op/A/B/tag=0, Issue_ready=1, Issue_tag=BASE_TAG. No pending state survives.
- Issue_ready, Issue_tag, Busy, and Fu_* depend on registered state only, never on same-cycle inputs.
- Issue with both operands ready at edge k: Fu_valid high in cycle k..k+1. Minimum issue-to-dispatch latency is 1 cycle.
- CDB capture at edge k -> READY -> Fu_valid in the following cycle.
- An entry freed at edge k is reissuable from edge k+1. There is no same-cycle free-and-reuse.
- Issue and CDB capture, dispatch, or free on different entries in the same cycle are all honoured.
- Fu_valid held with unchanged payload until accepted, unless a lower-index entry becomes READY. Re-selection is allowed, because the FU samples only on handshake.

## Configuration
- RS_CDB_BYPASS_EN defined: at issue, if Cdb_valid and Issue_Qj (or Issue_Qk) equals nonzero Cdb_tag, the entry loads Cdb_data with Q=0. This can make it READY immediately.
- Undefined: issue loads Issue_V/Issue_Q verbatim. The same-cycle broadcast is missed, and the issue stage must forward it itself.

## Test plan
- Reset mid-WAIT: issue op=2, Qj=2 -> assert Reset -> Busy=0, Fu_valid=0, Issue_tag=1. A subsequent CDB tag=2 has no effect.
- Ready issue: op=1, Vj=5, Vk=7, Q=0 -> next cycle Fu_valid=1, Fu_op=1, Fu_A=5, Fu_B=7, Fu_tag=1. Fu_ready=1 -> entry EXEC, Fu_valid=0. CDB tag=1 -> Busy=0.
- Snoop: issue Qj=3, Vk=4 -> CDB tag=3 data=0x00AA -> next cycle Fu_A=0x00AA, Fu_B=4. CDB tag=5 before that leaves it WAIT.
- Full: N=2, two issues -> Issue_ready=0, Issue_tag=0, third Issue_valid ignored. Free entry 1 via CDB tag=2 -> Issue_ready=1, Issue_tag=2.
- Priority/stall: both entries READY, Fu_ready=0 for 3 cycles -> Fu_tag=1 stable. Accept -> Fu_tag=2 next cycle.
- Bypass: issue Qj=4 with Cdb_valid, Cdb_tag=4, data=9 at the same edge. With RS_CDB_BYPASS_EN: Fu_valid next cycle, Fu_A=9. Without: entry stays WAIT.
